// File: rtl/noc_switch_pkg.sv
// Shared definitions for the mesh XY switch: output-port index map, arbiter
// state encoding, default port count and a modulo-wrap helper.
// No ports (package).
package noc_switch_pkg;

    // Port index map, shared with the XY router and the fixed-priority arbiter.
    localparam int RESOURCE = 0;
    localparam int WEST     = 1;
    localparam int EAST     = 2;
    localparam int NORTH    = 3;
    localparam int SOUTH    = 4;

    localparam int PORT_N_DEFAULT = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // (base + offs) mod n for base < n and offs < n. A conditional subtract
    // is used so that non-power-of-2 port counts wrap correctly.
    function automatic int wrap_add(input int base, input int offs, input int n);
        int sum;
        sum = base + offs;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker. Searches req_i starting at ptr_i,
// ascending with wrap-around; the first set bit wins.
// Ports:
//   req_i      in   PORT_N          request vector
//   ptr_i      in   $clog2(PORT_N)  index with the highest priority
//   winner_o   out  $clog2(PORT_N)  index of the winning request (0 if none)
//   any_req_o  out  1               at least one request is set
module rr_priority_picker
    import noc_switch_pkg::*;
#(
    parameter int PORT_N = PORT_N_DEFAULT
) (
    input  logic [PORT_N-1:0]         req_i,
    input  logic [$clog2(PORT_N)-1:0] ptr_i,
    output logic [$clog2(PORT_N)-1:0] winner_o,
    output logic                      any_req_o
);

    localparam int SEL_W = $clog2(PORT_N);

    logic [SEL_W-1:0] w_idx [PORT_N];

    // NOTE: every output is given a default before the search loop so no
    // path leaves a value unassigned, which would infer a latch.
    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        for (int i = 0; i < PORT_N; i++) begin
            w_idx[i] = SEL_W'(wrap_add(int'(ptr_i), i, PORT_N));
            if (!any_req_o && req_i[w_idx[i]]) begin
                winner_o  = w_idx[i];
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin output-port arbiter with wormhole lock and lock watchdog.
// One instance per switch output port. Grants one input for a whole packet,
// drives the crossbar select and per-input ready, and forces a release when
// the locked sender stops transferring for TIMEOUT cycles.
// Ports:
//   clk_i         in   1               clock, rising edge
//   rst_ni        in   1               async active-low reset
//   vld_i         in   PORT_N          per-input flit valid
//   last_i        in   PORT_N          per-input tail flag, qualified by vld_i
//   out_rdy_i     in   1               downstream ready
//   out_vld_o     out  1               output flit valid
//   in_rdy_o      out  PORT_N          per-input ready, at most one bit set
//   mux_in_sel_o  out  $clog2(PORT_N)  crossbar select (granted input)
//   grant_o       out  PORT_N          one-hot grant, zero when idle
//   timeout_o     out  1               one-cycle pulse on forced release
module rr_packet_arbiter
    import noc_switch_pkg::*;
#(
    parameter int PORT_N  = PORT_N_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [PORT_N-1:0]         vld_i,
    input  logic [PORT_N-1:0]         last_i,
    input  logic                      out_rdy_i,
    output logic                      out_vld_o,
    output logic [PORT_N-1:0]         in_rdy_o,
    output logic [$clog2(PORT_N)-1:0] mux_in_sel_o,
    output logic [PORT_N-1:0]         grant_o,
    output logic                      timeout_o
);

    localparam int SEL_W  = $clog2(PORT_N);
    localparam int WDOG_W = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_e        r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_sel;
    logic [WDOG_W-1:0] r_wdog;
    logic [PORT_N-1:0] r_grant;
    logic              r_timeout;

    logic [SEL_W-1:0]  w_winner;
    logic              w_any_req;
    logic              w_locked;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_sel_next;

    rr_priority_picker #(
        .PORT_N (PORT_N)
    ) u_picker (
        .req_i     (vld_i),
        .ptr_i     (r_ptr),
        .winner_o  (w_winner),
        .any_req_o (w_any_req)
    );

    assign w_locked   = (r_state == LOCKED);
    assign w_xfer     = w_locked & vld_i[r_sel] & out_rdy_i;
    assign w_sel_next = SEL_W'(wrap_add(int'(r_sel), 1, PORT_N));

    // Datapath handshake is combinational off the lock state; out_vld_o
    // never looks at out_rdy_i, so no valid/ready loop can form.
    assign out_vld_o    = w_locked & vld_i[r_sel];
    assign in_rdy_o     = (w_locked & out_rdy_i) ? (PORT_N'(1) << r_sel) : '0;
    assign mux_in_sel_o = r_sel;
    assign grant_o      = r_grant;
    assign timeout_o    = r_timeout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, and reset is asynchronous so a lock is
    // dropped the moment rst_ni falls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_wdog    <= '0;
            r_grant   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_sel   <= w_winner;
                        r_grant <= PORT_N'(1) << w_winner;
                        r_wdog  <= '0;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_xfer) begin
                        // A transfer always beats the watchdog.
                        r_wdog <= '0;
                        if (last_i[r_sel]) begin
                            r_ptr   <= w_sel_next;
                            r_grant <= '0;
                            r_state <= IDLE;
                        end
                    end else if (r_wdog == WDOG_LAST) begin
                        r_timeout <= 1'b1;
                        r_ptr     <= w_sel_next;
                        r_grant   <= '0;
                        r_wdog    <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed self-checking bench for rr_packet_arbiter (PORT_N=5, TIMEOUT=64).
module tb_rr_packet_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] vld_i;
    logic [4:0] last_i;
    logic       out_rdy_i;
    logic       out_vld_o;
    logic [4:0] in_rdy_o;
    logic [2:0] mux_in_sel_o;
    logic [4:0] grant_o;
    logic       timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    rr_packet_arbiter #(
        .PORT_N  (5),
        .TIMEOUT (64)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .vld_i        (vld_i),
        .last_i       (last_i),
        .out_rdy_i    (out_rdy_i),
        .out_vld_o    (out_vld_o),
        .in_rdy_o     (in_rdy_o),
        .mux_in_sel_o (mux_in_sel_o),
        .grant_o      (grant_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit observed=expired expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [4:0] exp_oh;
        int         exp_port;

        // Reset with every input requesting.
        rst_ni    = 1'b0;
        vld_i     = 5'b11111;
        last_i    = 5'b11111;
        out_rdy_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #3;
        check("rst_grant",   grant_o,      0);
        check("rst_out_vld", out_vld_o,    0);
        check("rst_in_rdy",  in_rdy_o,     0);
        check("rst_mux",     mux_in_sel_o, 0);
        check("rst_timeout", timeout_o,    0);

        rst_ni = 1'b1;
        step();
        #1;
        check("rel_grant", grant_o,      5'b00001);
        check("rel_mux",   mux_in_sel_o, 0);

        // Round-robin rotation of single-flit packets: 0,1,2,3,4,0.
        for (int k = 0; k < 6; k++) begin
            exp_port = k % 5;
            exp_oh   = 5'b00001 << exp_port;
            check("rot_grant",   grant_o,      exp_oh);
            check("rot_mux",     mux_in_sel_o, exp_port);
            check("rot_in_rdy",  in_rdy_o,     exp_oh);
            check("rot_out_vld", out_vld_o,    1);
            step();
            if (k == 5) vld_i = 5'b00000;
            #1;
            check("rot_bubble_grant",  grant_o,   0);
            check("rot_bubble_in_rdy", in_rdy_o,  0);
            check("rot_bubble_vld",    out_vld_o, 0);
            step();
            #1;
        end
        check("rot_idle_grant", grant_o, 0);

        // Wormhole: NORTH sends 4 flits while WEST waits.
        vld_i  = 5'b01000;
        last_i = 5'b00000;
        step();
        vld_i = 5'b01010;
        for (int f = 1; f <= 4; f++) begin
            last_i = (f == 4) ? 5'b01010 : 5'b00010;
            #1;
            check("worm_mux",     mux_in_sel_o, 3);
            check("worm_in_rdy",  in_rdy_o,     5'b01000);
            check("worm_out_vld", out_vld_o,    1);
            step();
        end
        vld_i = 5'b00010;
        #1;
        check("worm_bubble_grant", grant_o, 0);
        step();
        #1;
        check("worm_next_grant", grant_o,      5'b00010);
        check("worm_next_mux",   mux_in_sel_o, 1);
        step();
        vld_i = 5'b00000;
        #1;
        check("worm_end_grant", grant_o, 0);

        // Backpressure: SOUTH wins from ptr=2, stalls 10 cycles mid-packet.
        vld_i  = 5'b10000;
        last_i = 5'b00000;
        step();
        #1;
        check("bp_grant", grant_o, 5'b10000);
        step();
        out_rdy_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_out_vld", out_vld_o,    1);
            check("bp_in_rdy",  in_rdy_o,     0);
            check("bp_mux",     mux_in_sel_o, 4);
            check("bp_timeout", timeout_o,    0);
            step();
        end
        out_rdy_i = 1'b1;
        last_i    = 5'b10000;
        #1;
        check("bp_resume_in_rdy", in_rdy_o, 5'b10000);
        check("bp_resume_grant",  grant_o,  5'b10000);
        step();
        vld_i = 5'b00000;
        #1;
        check("bp_done_grant", grant_o,   0);
        check("bp_done_tmo",   timeout_o, 0);

        // Watchdog: EAST transfers one flit then goes silent.
        vld_i  = 5'b00100;
        last_i = 5'b00000;
        step();
        #1;
        check("wd_grant", grant_o, 5'b00100);
        step();
        vld_i = 5'b00000;
        for (int i = 1; i <= 63; i++) begin
            step();
            #1;
            check("wd_no_timeout", timeout_o, 0);
        end
        check("wd_still_locked", grant_o, 5'b00100);
        step();
        vld_i = 5'b10101;
        #1;
        check("wd_timeout_pulse", timeout_o, 1);
        check("wd_released",      grant_o,   0);
        step();
        #1;
        check("wd_pulse_end",   timeout_o,    0);
        check("wd_next_search", grant_o,      5'b10000);
        check("wd_next_mux",    mux_in_sel_o, 4);

        // Asynchronous reset between edges during a lock.
        check("ar_pre_vld", out_vld_o, 1);
        #1;
        rst_ni = 1'b0;
        #2;
        check("ar_out_vld", out_vld_o,    0);
        check("ar_grant",   grant_o,      0);
        check("ar_in_rdy",  in_rdy_o,     0);
        check("ar_mux",     mux_in_sel_o, 0);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        vld_i  = 5'b11111;
        step();
        #1;
        check("ar_ptr_zero_grant", grant_o,      5'b00001);
        check("ar_ptr_zero_mux",   mux_in_sel_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Sequential round-robin output-port arbiter for the simple mesh XY switch; one instance per output port.
- Grants one input port at a time and holds the grant for a whole multi-flit packet (wormhole lock) until the tail flit transfers.
- Drives the output crossbar mux select and the per-input ready lines.
- Includes a lock watchdog so a stalled sender cannot hold the output forever.

Parameters:
- PORT_N, 5, number of input ports; index map RESOURCE=0, WEST=1, EAST=2, NORTH=3, SOUTH=4.
- TIMEOUT, 64, cycles without a transfer while locked before a forced release; must be >= 2.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- vld_i  input  PORT_N  per-input flit valid, already routed to this output.
- last_i  input  PORT_N  per-input tail-flit flag; qualified by vld_i.
- out_rdy_i  input  1  downstream ready for this output.
- out_vld_o  output  1  output flit valid.
- in_rdy_o  output  PORT_N  per-input ready; at most one bit set.
- mux_in_sel_o  output  $clog2(PORT_N)  crossbar select, index of the granted input.
- grant_o  output  PORT_N  one-hot grant; all zero when idle.
- timeout_o  output  1  one-cycle pulse on forced release.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, ptr=0, sel=0, wdog=0, grant_o=0, mux_in_sel_o=0, out_vld_o=0, in_rdy_o=0, timeout_o=0.
- Reset asserted mid-packet aborts the lock immediately; no flit is accepted while rst_ni=0.
- Search order: start at index ptr and ascend with wrap-around modulo PORT_N. The first set bit of vld_i wins.
- IDLE state:
  - out_vld_o=0 and in_rdy_o=0.
  - If |vld_i, register sel=winner and grant_o=onehot(winner), clear wdog, and go to LOCKED.
  - Arbitration latency is 1 cycle: a flit offered in cycle N can transfer no earlier than cycle N+1.
- LOCKED state:
  - out_vld_o = vld_i[sel], combinational.
  - in_rdy_o[sel] = out_rdy_i; all other bits are 0.
  - mux_in_sel_o = sel and is stable for the whole lock.
  - A transfer is vld_i[sel] & out_rdy_i.
- Transfer with last_i[sel]=1:
  - ptr = (sel+1) mod PORT_N, computed without a power-of-2 assumption (sel==PORT_N-1 wraps to 0).
  - grant_o=0 and state=IDLE on the next edge.
  - This produces a mandatory one-cycle idle bubble between packets.
- Single-flit packet: the head flit has last_i=1 and is handled exactly like a tail.
- Watchdog:
  - In LOCKED, wdog increments each cycle without a transfer and clears on any transfer.
  - When wdog reaches TIMEOUT-1 and there is still no transfer, the block pulses timeout_o=1 for one cycle, sets ptr=(sel+1) mod PORT_N, and goes to IDLE.
  - A transfer in that same cycle takes priority: no timeout is raised.
  - wdog width is $clog2(TIMEOUT); it never wraps.
- Valid changes during a lock:
  - vld_i on non-granted ports is ignored.
  - vld_i[sel] dropping mid-packet is legal: the block stays LOCKED and wdog runs.
- out_rdy_i may toggle freely. out_vld_o does not depend on out_rdy_i, so there is no combinational loop.
- Fairness: each requester is served within PORT_N-1 other packets.

Decomposition:
- Shared package noc_switch_pkg:
  - port index constants RESOURCE/WEST/EAST/NORTH/SOUTH, shared with the XY router and the fixed-priority arbiter;
  - arbiter state encoding IDLE=1'b0, LOCKED=1'b1;
  - PORT_N default.
- Sub-module rr_priority_picker: combinational; inputs req[PORT_N] and ptr; outputs winner index and any_req. Reused by future VC allocators.
- The top level holds the FSM, ptr, sel and wdog.

Test Plan:
- Reset and idle: rst_ni=0 with vld_i=5'b11111 -> all outputs 0. Release reset -> grant_o=5'b00001 one cycle later, mux_in_sel_o=0.
- Round-robin rotation: vld_i=5'b11111 held, every flit last_i=1, out_rdy_i=1 -> grant sequence 0,1,2,3,4,0 with one idle cycle between grants.
- Wormhole hold: port 3 (NORTH) sends 4 flits, tail on the 4th, while port 1 is valid throughout -> mux_in_sel_o=3 for all 4 transfers, port 1 granted 2 cycles after the tail, in_rdy_o[1]=0 during the lock.
- Backpressure: out_rdy_i low for 10 cycles mid-packet -> out_vld_o=1, no transfer, sel unchanged, no timeout_o. The packet completes after out_rdy_i returns.
- Watchdog: lock port 2, then drop vld_i[2] with TIMEOUT=64 -> timeout_o pulses exactly 64 cycles after the last transfer, state returns to IDLE, and the next search starts at port 3.
- Async reset mid-packet: assert rst_ni between clock edges during a lock -> outputs clear immediately without waiting for a clock edge; ptr=0 after release.
